mdp3_encoder: RTL and testbench
===============================

# mdp3_encoder

Transmit-side counterpart of the MDP3 parser: accepts one decoded book-update record (action, entry type, security ID, price, quantity, order count) per handshake and serializes it into six 64-bit bus beats in the exact wire layout the parser consumes. It sits between the order generator / test stimulus source and the message FIFO that feeds the parser, and is used for loopback verification and outbound feed generation. Multi-byte fields are emitted little-endian (byte-reversed relative to the record), so a round trip through the parser reproduces the record exactly.

## Interface
- HEADER_WORD, 64'h0, constant emitted on beat 1.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low (reset==0 resets).
- in_valid  in  1  record valid.
- in_ready  out  1  encoder can accept a record this cycle.
- ACTION  in  2  0=NEW, 1=CHANGE, 2=DELETE.
- ENTRY_TYPE  in  2  0=BID, 1=OFFER.
- SECURITY_ID  in  32  instrument ID.
- PRICE  in  64  price.
- QUANTITY  in  16  quantity.
- NUM_ORDERS  in  8  order count.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream FIFO accepts beat.
- out_data  out  64  beat payload.
- out_sop / out_eop  out  1  high on beat 0 / beat 5.
- seq_num  out  32  sequence number of the next message.

## Operation
- Accept = in_valid && in_ready; all fields are latched on accept and held stable for the full message.
- FSM: IDLE, SEND. IDLE --accept--> SEND with beat=0. In SEND, beat advances on out_valid && out_ready. beat 5 handshake -> IDLE, or stays in SEND with beat=0 if a new record is accepted in that same cycle.
- in_ready = (state==IDLE) || (state==SEND && beat==5 && out_ready); low while reset is asserted.
- Beat layout (SID_LE = byte-reversed SECURITY_ID, PRICE_LE = byte-reversed PRICE; unlisted bits 0):
  - beat0: [63:32] = byte-reversed seq_num latched on accept.
  - beat1: HEADER_WORD.
  - beat2: [25:24] ACTION, [17:16] ENTRY_TYPE, [15:0] SID_LE[31:16].
  - beat3: [63:48] SID_LE[15:0], [15:0] PRICE_LE[63:48].
  - beat4: [63:16] PRICE_LE[47:0], [15:0] byte-reversed QUANTITY.
  - beat5: [63:56] NUM_ORDERS.
- seq_num increments by 1 on every accept and wraps from 32'hFFFF_FFFF to 0.
- out_data = 0 whenever out_valid = 0.

## Timing
- Reset values: state IDLE, beat 0, out_valid 0, out_data 0, out_sop 0, out_eop 0, seq_num 0, latched fields 0. in_ready is 1 in the first cycle after reset deasserts.
- Latency: record accepted at edge N, so beat 0 is presented (out_valid=1) after edge N.
- A beat holds out_data, out_sop and out_eop stable until it is handshaken. out_valid never drops mid-message.
- Back-to-back messages: 6 cycles per message with no bubble when out_ready is held high.
- out_ready low stalls on the current beat indefinitely, with no change to seq_num.
- Reset mid-message: the message is discarded with no out_eop, out_valid drops at the reset edge, and the next message carries seq 0.
- in_valid while busy and not on the final beat: the record is not accepted, and the source holds it.

## Structure
- mdp3_pkg (shared with the parser) holds:
  - the action_t and entry_type_t enums;
  - the BEAT_COUNT=6 constant;
  - the bit-position constants for each field;
  - byteswap16/32/64 functions.
- No sub-module. The beat mux is a case on beat inside mdp3_encoder.

## Test plan
- After reset, send ACTION=1, ENTRY_TYPE=2, SECURITY_ID=32'h11223344, PRICE=64'h0102030405060708, QUANTITY=16'hABCD, NUM_ORDERS=8'h05 with out_ready=1. Required beats: 64'h0, HEADER_WORD, 64'h0000_0000_0102_4433, 64'h2211_0000_0000_0807, 64'h0605_0403_0201_CDAB, 64'h0500_0000_0000_0000. sop on beat 0, eop on beat 5.
- Loopback of the above record into MDP3 parser: the parser outputs SECURITY_ID=32'h11223344, PRICE=64'h0102030405060708, QUANTITY=16'hABCD, NUM_ORDERS=8'h05.
- Three records back-to-back with out_ready=1: 18 consecutive valid beats; beat-0 [63:32] values 0, 32'h0100_0000, 32'h0200_0000.
- Random out_ready low (about 50%) during a message: every beat is held stable while stalled, and the beat sequence matches the first test.
- Preload seq_num to 32'hFFFF_FFFF and send two messages: beat-0 [63:32] values 32'hFFFF_FFFF, then 0.
- Assert reset on beat 3: out_valid is 0 the next cycle and no eop is emitted. The next message starts at beat 0 with seq 0.

Source files
------------

// File: rtl/mdp3_pkg.sv
// Shared MDP3 definitions: field enums, beat count, wire bit positions and
// byte-swap helpers used by both the parser and the encoder.
package mdp3_pkg;

  typedef enum logic [1:0] {
    ACT_NEW    = 2'd0,
    ACT_CHANGE = 2'd1,
    ACT_DELETE = 2'd2
  } action_t;

  typedef enum logic [1:0] {
    ENT_BID   = 2'd0,
    ENT_OFFER = 2'd1
  } entry_type_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } enc_state_t;

  localparam int          BEAT_COUNT  = 6;
  localparam logic [63:0] HEADER_WORD = 64'h0;

  // Field positions within their beat
  localparam int SEQ_LSB        = 32;  // beat 0
  localparam int ACTION_LSB     = 24;  // beat 2
  localparam int ENTRY_TYPE_LSB = 16;  // beat 2
  localparam int SID_HI_LSB     = 0;   // beat 2, SID_LE[31:16]
  localparam int SID_LO_LSB     = 48;  // beat 3, SID_LE[15:0]
  localparam int PRICE_HI_LSB   = 0;   // beat 3, PRICE_LE[63:48]
  localparam int PRICE_LO_LSB   = 16;  // beat 4, PRICE_LE[47:0]
  localparam int QTY_LSB        = 0;   // beat 4
  localparam int NUM_ORD_LSB    = 56;  // beat 5

  function automatic logic [15:0] byteswap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [31:0] byteswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [63:0] byteswap64(input logic [63:0] v);
    return {byteswap32(v[31:0]), byteswap32(v[63:32])};
  endfunction

endpackage

// File: rtl/mdp3_encoder.sv
// Serializes one book-update record into six little-endian 64-bit beats
// in the layout consumed by the MDP3 parser.
module mdp3_encoder
  import mdp3_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  ACTION,
  input  logic [1:0]  ENTRY_TYPE,
  input  logic [31:0] SECURITY_ID,
  input  logic [63:0] PRICE,
  input  logic [15:0] QUANTITY,
  input  logic [7:0]  NUM_ORDERS,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic [31:0] seq_num
);

  localparam logic [2:0] LAST_BEAT = 3'(BEAT_COUNT - 1);

  enc_state_t  state, state_next;
  logic [2:0]  beat, beat_next;
  logic [31:0] seq_next;
  logic        accept, beat_done, last_beat;

  logic [1:0]  action_q, entry_type_q;
  logic [31:0] sid_q, seq_q;
  logic [63:0] price_q;
  logic [15:0] qty_q;
  logic [7:0]  num_orders_q;

  assign last_beat = (beat == LAST_BEAT);
  assign out_valid = (state == ST_SEND);
  assign out_sop   = out_valid && (beat == 3'd0);
  assign out_eop   = out_valid && last_beat;
  assign beat_done = out_valid && out_ready;
  // The final handshake frees the encoder, so a new record may overlap it
  assign in_ready  = reset && ((state == ST_IDLE) ||
                               ((state == ST_SEND) && last_beat && out_ready));
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_next = state;
    beat_next  = beat;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SEND;
          beat_next  = 3'd0;
        end
      end
      ST_SEND: begin
        if (beat_done) begin
          if (last_beat) begin
            state_next = accept ? ST_SEND : ST_IDLE;
            beat_next  = 3'd0;
          end else begin
            beat_next  = beat + 3'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        beat_next  = 3'd0;
      end
    endcase
  end

  always_comb begin
    seq_next = seq_num;
    if (accept) seq_next = seq_num + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      beat    <= 3'd0;
      seq_num <= 32'd0;
    end else begin
      state   <= state_next;
      beat    <= beat_next;
      seq_num <= seq_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      action_q     <= 2'd0;
      entry_type_q <= 2'd0;
      sid_q        <= 32'd0;
      price_q      <= 64'd0;
      qty_q        <= 16'd0;
      num_orders_q <= 8'd0;
      seq_q        <= 32'd0;
    end else if (accept) begin
      action_q     <= ACTION;
      entry_type_q <= ENTRY_TYPE;
      sid_q        <= byteswap32(SECURITY_ID);
      price_q      <= byteswap64(PRICE);
      qty_q        <= byteswap16(QUANTITY);
      num_orders_q <= NUM_ORDERS;
      seq_q        <= byteswap32(seq_num);
    end
  end

  // Latched fields are already little-endian; this only places them
  always_comb begin
    out_data = 64'h0;
    if (out_valid) begin
      case (beat)
        3'd0: out_data[SEQ_LSB +: 32] = seq_q;
        3'd1: out_data = HEADER_WORD;
        3'd2: begin
          out_data[ACTION_LSB +: 2]     = action_q;
          out_data[ENTRY_TYPE_LSB +: 2] = entry_type_q;
          out_data[SID_HI_LSB +: 16]    = sid_q[31:16];
        end
        3'd3: begin
          out_data[SID_LO_LSB +: 16]   = sid_q[15:0];
          out_data[PRICE_HI_LSB +: 16] = price_q[63:48];
        end
        3'd4: begin
          out_data[PRICE_LO_LSB +: 48] = price_q[47:0];
          out_data[QTY_LSB +: 16]      = qty_q;
        end
        3'd5: out_data[NUM_ORD_LSB +: 8] = num_orders_q;
        default: out_data = 64'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mdp3_encoder.sv
// Directed bench for mdp3_encoder with a beat scoreboard and a stall monitor.
module tb_mdp3_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  action = 2'd0;
  logic [1:0]  entry_type = 2'd0;
  logic [31:0] security_id = 32'd0;
  logic [63:0] price = 64'd0;
  logic [15:0] quantity = 16'd0;
  logic [7:0]  num_orders = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_sop, out_eop;
  logic [31:0] seq_num;

  always #5 clk = ~clk;

  mdp3_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ACTION(action), .ENTRY_TYPE(entry_type), .SECURITY_ID(security_id),
    .PRICE(price), .QUANTITY(quantity), .NUM_ORDERS(num_orders),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .seq_num(seq_num)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          rnd_mode = 1'b0;
  int          run_len = 0;
  int          max_run = 0;
  int          eop_cnt = 0;
  int          cap_i = 0;
  logic [63:0] cap [6];
  logic [31:0] exp_seq = 32'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rev(input logic [63:0] v, input int nbytes);
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < nbytes; i++) r[8*i +: 8] = v[8*(nbytes-1-i) +: 8];
    return r;
  endfunction

  task automatic push_beat(input logic [63:0] d, input logic s, input logic e);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e;
    exp_q.push_back(b);
  endtask

  task automatic push_model(input logic [1:0] a, input logic [1:0] e, input logic [31:0] sid,
                            input logic [63:0] pr, input logic [15:0] q, input logic [7:0] no,
                            input logic [31:0] seq);
    logic [63:0] sle, ple, qle, sqle;
    sqle = rev(64'(seq), 4);
    sle  = rev(64'(sid), 4);
    ple  = rev(pr, 8);
    qle  = rev(64'(q), 2);
    push_beat({sqle[31:0], 32'h0}, 1'b1, 1'b0);
    push_beat(64'h0, 1'b0, 1'b0);
    push_beat({38'h0, a, 6'h0, e, sle[31:16]}, 1'b0, 1'b0);
    push_beat({sle[15:0], 32'h0, ple[63:48]}, 1'b0, 1'b0);
    push_beat({ple[47:0], qle[15:0]}, 1'b0, 1'b0);
    push_beat({no, 56'h0}, 1'b0, 1'b1);
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [1:0] a, input logic [1:0] e, input logic [31:0] sid,
                      input logic [63:0] pr, input logic [15:0] q, input logic [7:0] no,
                      input bit use_model);
    int n;
    if (use_model) push_model(a, e, sid, pr, q, no, exp_seq);
    exp_seq = exp_seq + 32'd1;
    action = a; entry_type = e; security_id = sid;
    price = pr; quantity = q; num_orders = no;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n < 200), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_in_reset", 64'(in_ready), 64'd0);
    reset = 1'b1;
    exp_q.delete();
    exp_seq = 32'd0;
    @(negedge clk);
  endtask

  task automatic push_test1_literals();
    push_beat(64'h0, 1'b1, 1'b0);
    push_beat(64'h0, 1'b0, 1'b0);
    push_beat(64'h0000_0000_0102_4433, 1'b0, 1'b0);
    push_beat(64'h2211_0000_0000_0807, 1'b0, 1'b0);
    push_beat(64'h0605_0403_0201_CDAB, 1'b0, 1'b0);
    push_beat(64'h0500_0000_0000_0000, 1'b0, 1'b1);
  endtask

  // Output monitor: scoreboard pop on handshake, hold check while stalled.
  initial begin
    logic        stalled;
    logic [63:0] h_data;
    logic        h_sop, h_eop;
    logic [31:0] h_seq;
    beat_t       b;
    stalled = 1'b0;
    h_data = 64'h0; h_sop = 1'b0; h_eop = 1'b0; h_seq = 32'h0;
    forever begin
      @(negedge clk);
      if (stalled && reset) begin
        chk("stall_data", out_data, h_data);
        chk("stall_flags", 64'({out_valid, out_sop, out_eop}), 64'({1'b1, h_sop, h_eop}));
        chk("stall_seq", 64'(seq_num), 64'(h_seq));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", out_data, 64'hDEAD_0000_0000_BEEF);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", out_data, b.data);
          chk("beat_sop_eop", 64'({out_sop, out_eop}), 64'({b.sop, b.eop}));
        end
        if (out_sop) cap_i = 0;
        if (cap_i < 6) cap[cap_i] = out_data;
        cap_i++;
        if (out_eop) eop_cnt++;
      end
      if (!out_valid) chk("idle_data_zero", out_data, 64'h0);
      stalled = out_valid && !out_ready;
      h_data = out_data; h_sop = out_sop; h_eop = out_eop; h_seq = seq_num;
      run_len = out_valid ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
    end
  end

  // Random backpressure, changed away from both edges used elsewhere
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [31:0] sid_rt;
    logic [63:0] price_rt;
    logic [15:0] qty_rt;
    int          eop_before;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_seq", 64'(seq_num), 64'd0);
    chk("post_rst_flags", 64'({out_valid, out_sop, out_eop}), 64'd0);

    // Single record, fixed wire image
    out_ready = 1'b1;
    push_test1_literals();
    send(2'd1, 2'd2, 32'h1122_3344, 64'h0102_0304_0506_0708, 16'hABCD, 8'h05, 1'b0);
    drain();
    chk("seq_after_one", 64'(seq_num), 64'd1);

    // Loopback decode of the captured beats
    sid_rt   = 32'(rev(64'({cap[2][15:0], cap[3][63:48]}), 4));
    price_rt = rev({cap[3][15:0], cap[4][63:16]}, 8);
    qty_rt   = 16'(rev(64'(cap[4][15:0]), 2));
    chk("rt_sid", 64'(sid_rt), 64'h1122_3344);
    chk("rt_price", price_rt, 64'h0102_0304_0506_0708);
    chk("rt_qty", 64'(qty_rt), 64'hABCD);
    chk("rt_num_orders", 64'(cap[5][63:56]), 64'h05);
    chk("rt_action", 64'(cap[2][25:24]), 64'd1);

    // Three back-to-back records
    do_reset();
    max_run = 0;
    send(2'd0, 2'd0, 32'hDEAD_BEEF, 64'hFEDC_BA98_7654_3210, 16'h1234, 8'h01, 1'b1);
    send(2'd2, 2'd1, 32'h0000_0001, 64'h8000_0000_0000_0001, 16'hFFFF, 8'hFF, 1'b1);
    send(2'd1, 2'd0, 32'hA5A5_5A5A, 64'h0000_0000_0000_0000, 16'h0000, 8'h80, 1'b1);
    drain();
    chk("b2b_run_len", 64'(max_run), 64'd18);
    chk("b2b_seq", 64'(seq_num), 64'd3);

    // Random stalls on the reference record
    do_reset();
    rnd_mode = 1'b1;
    push_test1_literals();
    send(2'd1, 2'd2, 32'h1122_3344, 64'h0102_0304_0506_0708, 16'hABCD, 8'h05, 1'b0);
    drain();
    rnd_mode = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);

    // Sequence number wrap
    do_reset();
    force dut.seq_num = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.seq_num;
    @(negedge clk);
    chk("preload_seq", 64'(seq_num), 64'hFFFF_FFFF);
    exp_seq = 32'hFFFF_FFFF;
    send(2'd0, 2'd1, 32'h0BAD_F00D, 64'h1111_2222_3333_4444, 16'h5566, 8'h07, 1'b1);
    send(2'd2, 2'd0, 32'h7777_8888, 64'h9999_AAAA_BBBB_CCCC, 16'hDDEE, 8'h09, 1'b1);
    drain();
    chk("wrap_seq", 64'(seq_num), 64'd1);

    // Reset during beat 3
    do_reset();
    eop_before = eop_cnt;
    send(2'd1, 2'd1, 32'hCAFE_0001, 64'h0123_4567_89AB_CDEF, 16'h4242, 8'h03, 1'b1);
    repeat (3) @(negedge clk);
    chk("at_beat3_valid", 64'(out_valid), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_eop", 64'(out_eop), 64'd0);
    reset = 1'b1;
    exp_q.delete();
    exp_seq = 32'd0;
    @(negedge clk);
    chk("midrst_no_eop", 64'(eop_cnt), 64'(eop_before));
    chk("midrst_seq", 64'(seq_num), 64'd0);
    send(2'd0, 2'd0, 32'h0000_00AA, 64'h0000_0000_0000_00BB, 16'h00CC, 8'hDD, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
